// File: rtl/port_arbiter.sv
// Round-robin arbiter for one switch output port. Grants one of PORTS_NUM+1
// requesters, forwards its flits downstream over a four-phase handshake and
// keeps the grant until the tail flit so packets from different requesters
// never interleave.
module port_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4
) (
  input  logic                                                clk,
  input  logic                                                a_rst,
  input  logic [PORTS_NUM:0]                                  req_i,
  input  logic [(DATA_SIZE+ADDR_SIZE+1)*(PORTS_NUM+1)-1:0]    data_i,
  output logic [PORTS_NUM:0]                                  ack_o,
  output logic                                                wr_ready_o,
  output logic [DATA_SIZE+ADDR_SIZE:0]                        data_o,
  input  logic                                                rd_ack_i,
  output logic [PORTS_NUM:0]                                  grant_o,
  output logic                                                locked_o
);

  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam int NREQ     = PORTS_NUM + 1;
  localparam int IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, ACK, HOLD} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                wr_ready_q, wr_ready_d;
  logic [BUS_SIZE-1:0] data_q, data_d;
  logic                locked_q, locked_d;
  logic [IDX_W-1:0]    rr_q, rr_d;

  logic                found;
  logic [IDX_W-1:0]    pick;

  // Round-robin search: first requester at or after rr_q, wrapping mod NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = int'(rr_q) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!found && req_i[c]) begin
        found = 1'b1;
        pick  = IDX_W'(c);
      end
    end
  end

  // Next-state and output logic of the grant/handshake FSM.
  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    state_d    = state_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    ack_d      = '0;
    wr_ready_d = wr_ready_q;
    data_d     = data_q;
    locked_d   = locked_q;
    rr_d       = rr_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          gidx_d     = pick;
          grant_d    = NREQ'(1) << pick;
          data_d     = data_i[pick*BUS_SIZE +: BUS_SIZE];
          wr_ready_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        // Flit is held stable until downstream consumes it, even if the
        // owner has already dropped its request.
        if (rd_ack_i) begin
          wr_ready_d = 1'b0;
          ack_d      = grant_q;
          state_d    = ACK;
        end
      end
      ACK: begin
        // Return-to-zero on both sides before the next flit or release.
        if (!req_i[gidx_q] && !rd_ack_i) begin
          if (data_q[ADDR_SIZE]) begin
            grant_d  = '0;
            locked_d = 1'b0;
            rr_d     = (gidx_q == IDX_W'(PORTS_NUM)) ? '0 : gidx_q + IDX_W'(1);
            state_d  = IDLE;
          end else begin
            locked_d = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        // Only the owner may continue; other requesters are ignored here.
        if (req_i[gidx_q]) begin
          data_d     = data_i[gidx_q*BUS_SIZE +: BUS_SIZE];
          wr_ready_d = 1'b1;
          state_d    = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (a_rst) begin
      state_q    <= IDLE;
      gidx_q     <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      wr_ready_q <= 1'b0;
      data_q     <= '0;
      locked_q   <= 1'b0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      wr_ready_q <= wr_ready_d;
      data_q     <= data_d;
      locked_q   <= locked_d;
      rr_q       <= rr_d;
    end
  end

  assign ack_o      = ack_q;
  assign wr_ready_o = wr_ready_q;
  assign data_o     = data_q;
  assign grant_o    = grant_q;
  assign locked_o   = locked_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Scoreboard bench for port_arbiter: tests push the expected (owner, flit)
// order, a monitor pops and compares on every ack_o pulse.
module tb_port_arbiter;

  localparam int DS  = 32;
  localparam int AS  = 4;
  localparam int PN  = 4;
  localparam int N   = PN + 1;
  localparam int BUS = DS + AS + 1;

  logic             clk = 1'b0;
  logic             a_rst = 1'b1;
  logic [N-1:0]     req_i = '0;
  logic [BUS*N-1:0] data_i = '0;
  logic             rd_ack_i = 1'b0;
  logic [N-1:0]     ack_o;
  logic             wr_ready_o;
  logic [BUS-1:0]   data_o;
  logic [N-1:0]     grant_o;
  logic             locked_o;

  port_arbiter #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .PORTS_NUM(PN)) dut (
    .clk(clk), .a_rst(a_rst), .req_i(req_i), .data_i(data_i), .ack_o(ack_o),
    .wr_ready_o(wr_ready_o), .data_o(data_o), .rd_ack_i(rd_ack_i),
    .grant_o(grant_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]   oh;
    logic [BUS-1:0] flit;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bit   ds_en = 1'b1;
  int   ds_delay = 1;
  int   ds_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [BUS-1:0] mk(input logic [DS-1:0] d, input logic tail,
                                        input logic [AS-1:0] addr);
    return {d, tail, addr};
  endfunction

  function automatic logic [BUS-1:0] pkt_flit(input logic [DS-1:0] base, input int f,
                                              input int n, input logic [AS-1:0] addr);
    return mk(base + DS'(f), (f == n - 1), addr);
  endfunction

  task automatic push(input int port, input logic [BUS-1:0] flit);
    exp_t e;
    e.oh   = N'(1) << port;
    e.flit = flit;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int port);
    bit got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (ack_o[port]) got = 1'b1;
    end
    if (!got) check($sformatf("ack_timeout_p%0d", port), 64'd0, 64'd1);
  endtask

  // Requester model: four-phase handshake per flit.
  task automatic send_pkt(input int port, input int n, input logic [DS-1:0] base,
                          input logic [AS-1:0] addr);
    for (int f = 0; f < n; f++) begin
      data_i[port*BUS +: BUS] = pkt_flit(base, f, n, addr);
      req_i[port] = 1'b1;
      wait_ack(port);
      req_i[port] = 1'b0;
      @(negedge clk);
      check($sformatf("ack_one_cycle_p%0d", port), 64'(ack_o[port]), 64'd0);
    end
  endtask

  // Downstream model: raise rd_ack ds_delay cycles after valid, drop after valid falls.
  initial forever begin
    @(negedge clk);
    if (a_rst) begin
      rd_ack_i = 1'b0;
      ds_cnt   = 0;
    end else if (rd_ack_i) begin
      if (!wr_ready_o) rd_ack_i = 1'b0;
    end else if (ds_en && wr_ready_o) begin
      ds_cnt++;
      if (ds_cnt >= ds_delay) begin
        rd_ack_i = 1'b1;
        ds_cnt   = 0;
      end
    end
  end

  // Monitor: every accepted flit must match the head of the expected queue.
  initial forever begin
    @(negedge clk);
    if (!a_rst) begin
      check("ack_wr_exclusive", 64'((|ack_o) & wr_ready_o), 64'd0);
      if (ack_o != '0) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_ack", 64'(ack_o), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_ack_owner", 64'(ack_o), 64'(e.oh));
          check("sb_grant", 64'(grant_o), 64'(e.oh));
          check("sb_data", 64'(data_o), 64'(e.flit));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [BUS-1:0] f;

    // 1: reset with all requesting, then first grant goes to port 0.
    for (int i = 0; i < N; i++) data_i[i*BUS +: BUS] = mk(32'hA0 + DS'(i), 1'b1, AS'(i));
    req_i = 5'h1F;
    repeat (2) @(negedge clk);
    check("reset_outputs", {ack_o, wr_ready_o, grant_o, locked_o, data_o}, 64'd0);
    push(0, mk(32'hA0, 1'b1, 4'h0));
    a_rst = 1'b0;
    @(negedge clk);
    check("first_grant_p0", {grant_o, wr_ready_o}, {5'b00001, 1'b1});
    req_i = '0;
    wait_ack(0);
    repeat (2) @(negedge clk);

    // 2: single flit from port 2, downstream acks 2 cycles after valid.
    ds_delay = 2;
    f = mk(32'h1234_5678, 1'b1, 4'h2);
    push(2, f);
    data_i[2*BUS +: BUS] = f;
    req_i[2] = 1'b1;
    @(negedge clk);
    check("req_to_valid", {wr_ready_o, grant_o}, {1'b1, 5'b00100});
    wait_ack(2);
    req_i[2] = 1'b0;
    @(negedge clk);
    check("ack_pulse_p2", 64'(ack_o), 64'd0);
    repeat (2) @(negedge clk);
    check("release_idle", {grant_o, locked_o, wr_ready_o, data_o}, {5'b0, 1'b0, 1'b0, f});
    ds_delay = 1;

    // 2b: pointer now at 3, so port 3 beats port 2, then port 2.
    push(3, pkt_flit(32'hC3, 0, 1, 4'h3));
    push(2, pkt_flit(32'hC2, 0, 1, 4'h2));
    fork
      send_pkt(2, 1, 32'hC2, 4'h2);
      send_pkt(3, 1, 32'hC3, 4'h3);
    join
    repeat (2) @(negedge clk);

    // 3: port 1 three-flit packet locks out port 3.
    for (int k = 0; k < 3; k++) push(1, pkt_flit(32'h100, k, 3, 4'h1));
    push(3, pkt_flit(32'h300, 0, 1, 4'h3));
    fork
      send_pkt(1, 3, 32'h100, 4'h1);
      begin
        repeat (3) @(negedge clk);
        send_pkt(3, 1, 32'h300, 4'h3);
      end
    join
    repeat (2) @(negedge clk);

    // 4: round robin from pointer 0 with everyone requesting.
    a_rst = 1'b1;
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    push(0, pkt_flit(32'h400, 0, 1, 4'h0));
    for (int p = 1; p < N; p++) push(p, pkt_flit(32'h400 + DS'(p), 0, 1, AS'(p)));
    push(0, pkt_flit(32'h480, 0, 1, 4'h0));
    fork
      begin
        send_pkt(0, 1, 32'h400, 4'h0);
        send_pkt(0, 1, 32'h480, 4'h0);
      end
      send_pkt(1, 1, 32'h401, 4'h1);
      send_pkt(2, 1, 32'h402, 4'h2);
      send_pkt(3, 1, 32'h403, 4'h3);
      send_pkt(4, 1, 32'h404, 4'h4);
    join
    repeat (2) @(negedge clk);

    // 5: back-pressure for 20 cycles, no ack and no regrant.
    ds_en = 1'b0;
    f = pkt_flit(32'h500, 0, 1, 4'h4);
    push(4, f);
    push(1, pkt_flit(32'h501, 0, 1, 4'h1));
    fork
      send_pkt(4, 1, 32'h500, 4'h4);
      begin
        repeat (3) @(negedge clk);
        send_pkt(1, 1, 32'h501, 4'h1);
      end
      begin
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          check("backpressure_hold", {wr_ready_o, ack_o, grant_o, data_o},
                {1'b1, 5'b0, 5'b10000, f});
        end
        ds_en = 1'b1;
      end
    join
    repeat (2) @(negedge clk);

    // 6: reset while holding a multi-flit packet, then re-arbitrate from 0.
    push(2, pkt_flit(32'h600, 0, 3, 4'h2));
    data_i[2*BUS +: BUS] = pkt_flit(32'h600, 0, 3, 4'h2);
    req_i[2] = 1'b1;
    wait_ack(2);
    req_i[2] = 1'b0;
    @(negedge clk);
    check("hold_locked", {locked_o, grant_o, wr_ready_o}, {1'b1, 5'b00100, 1'b0});
    a_rst = 1'b1;
    @(negedge clk);
    check("reset_abort", {locked_o, grant_o, wr_ready_o, ack_o, data_o}, 64'd0);
    a_rst = 1'b0;
    push(0, pkt_flit(32'h700, 0, 1, 4'h0));
    push(3, pkt_flit(32'h703, 0, 1, 4'h3));
    fork
      send_pkt(3, 1, 32'h703, 4'h3);
      send_pkt(0, 1, 32'h700, 4'h0);
      begin
        @(negedge clk);
        check("regrant_after_reset", {grant_o, locked_o}, {5'b00001, 1'b0});
      end
    join

    repeat (5) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
